instr_loader: RTL and testbench

- Writer side of the 11-bit instruction-memory interface: takes opcode/operand pairs over a valid/ready stream and packs them as {opcode[2:0], operand[7:0]}.
- Pack format is the inverse of the decoder split.
- Writes packed words to sequential 6-bit memory addresses using the memory's rw/addr/data port (rw=0 write, rw=1 read).
- Sits between a host/test stream and the instruction memory. Drives memory only during a load session; parks in read mode otherwise.

---
 rtl/instr_loader_if.sv | 41 ++++
 rtl/instr_loader.sv | 133 +++++++++++++
 tb/tb_instr_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Host-stream, session-control and memory-port signals of the instruction loader.
// Build option LOADER_CHECKSUM_EN adds the checksum signal.
interface instr_loader_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic [ADDR_W:0]   count;
   logic              abort;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_opcode;
   logic [7:0]        in_operand;
   logic              mem_wait;
   logic [ADDR_W-1:0] mem_addr;
   logic [10:0]       mem_wdata;
   logic              mem_rw;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   words_written;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        checksum;

   modport master (
      output start, count, abort, in_valid, in_opcode, in_operand, mem_wait,
      input  in_ready, mem_addr, mem_wdata, mem_rw, busy, done, words_written, checksum
   );
   modport slave (
      input  start, count, abort, in_valid, in_opcode, in_operand, mem_wait,
      output in_ready, mem_addr, mem_wdata, mem_rw, busy, done, words_written, checksum
   );
`else
   modport master (
      output start, count, abort, in_valid, in_opcode, in_operand, mem_wait,
      input  in_ready, mem_addr, mem_wdata, mem_rw, busy, done, words_written
   );
   modport slave (
      input  start, count, abort, in_valid, in_opcode, in_operand, mem_wait,
      output in_ready, mem_addr, mem_wdata, mem_rw, busy, done, words_written
   );
`endif
endinterface

// File: rtl/instr_loader.sv
// Packs {opcode, operand} stream words and writes them to sequential instruction-memory
// addresses during a load session. Build option LOADER_CHECKSUM_EN adds a per-session checksum.
module instr_loader #(
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   instr_loader_if.slave bus
);
   localparam int              PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(2 ** ADDR_W);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            state, state_next;
   logic [ADDR_W:0]   target, accepted, words_written;
   logic [ADDR_W-1:0] mem_addr;
   logic [10:0]       mem_wdata;
   logic              mem_rw, done, done_next;
   logic [10:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [PTR_W:0]    fifo_count;
   logic [10:0]       head;
   logic              in_ready, push, issue, session_start, zero_start;

   assign session_start = (state == IDLE) && bus.start && (bus.count != '0);
   assign zero_start    = (state == IDLE) && bus.start && (bus.count == '0);
   assign in_ready      = (state == RUN) && (fifo_count != FIFO_FULL) && (accepted < target);
   // abort wins over a same-cycle push or issue, so neither happens on that edge
   assign push          = in_ready && bus.in_valid && !bus.abort;
   assign issue         = (state == RUN) && !bus.abort && (fifo_count != '0) && !bus.mem_wait;
   assign head          = fifo_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: defaults come first so no path leaves a variable unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (session_start) state_next = RUN;
         RUN: begin
            if (bus.abort)                    state_next = IDLE;
            else if (words_written == target) state_next = FIN;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      done_next = zero_start || ((state == RUN) && (state_next == FIN));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target        <= '0;
         accepted      <= '0;
         words_written <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_rw        <= 1'b1;
         done          <= 1'b0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         fifo_count    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         done   <= done_next;
         mem_rw <= !issue;
         if (session_start) begin
            target        <= bus.count[ADDR_W] ? MAX_WORDS : bus.count;
            accepted      <= '0;
            words_written <= '0;
            mem_addr      <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + 1'b1;
               accepted <= accepted + 1'b1;
            end
            // write address is the count of prior writes; it advances once the strobe ends
            if (issue) begin
               rd_ptr        <= rd_ptr + 1'b1;
               mem_wdata     <= head;
               mem_addr      <= words_written[ADDR_W-1:0];
               words_written <= words_written + 1'b1;
            end else if (!mem_rw) begin
               mem_addr <= mem_addr + 1'b1;
            end
            if ((state == RUN) && bus.abort) begin
               rd_ptr     <= '0;
               wr_ptr     <= '0;
               fifo_count <= '0;
            end else begin
               case ({push, issue})
                  2'b10:   fifo_count <= fifo_count + 1'b1;
                  2'b01:   fifo_count <= fifo_count - 1'b1;
                  default: fifo_count <= fifo_count;
               endcase
            end
         end
      end
   end

   // NOTE: buffer storage is not reset; the occupancy count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {bus.in_opcode, bus.in_operand};
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                checksum <= '0;
      else if (session_start) checksum <= '0;
      else if (issue)         checksum <= checksum + 8'(head[10:8]) + head[7:0];
   end

   assign bus.checksum = checksum;
`endif

   assign bus.in_ready      = in_ready;
   assign bus.mem_addr      = mem_addr;
   assign bus.mem_wdata     = mem_wdata;
   assign bus.mem_rw        = mem_rw;
   assign bus.busy          = (state != IDLE);
   assign bus.done          = done;
   assign bus.words_written = words_written;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: session table plus hand-written abort/reset/zero-count
// sequences; every memory write strobe is checked against a scoreboard queue.
module tb_instr_loader;
   typedef struct {
      logic [2:0]  opc;
      logic [7:0]  opr;
      logic [10:0] exp;
   } word_t;

   typedef struct {
      logic [5:0]  addr;
      logic [10:0] data;
   } exp_t;

   typedef struct {
      logic [6:0] count;
      int         exp_writes;
      int         stall;
      bit         extra_start;
   } sess_t;

   logic clk;
   logic rst;

   instr_loader_if #(.ADDR_W(6)) bus ();

   instr_loader #(.ADDR_W(6), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         checks = 0;
   int         failures = 0;
   int         cyc_cnt = 0;
   int         writes_seen = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         first_wr_cyc = 0;
   int         last_wr_cyc = 0;
   int         first_acc_cyc = 0;
   int         sent_cnt = 0;
   logic [5:0] exp_addr = '0;
   word_t      src_q[$];
   exp_t       exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Write monitor: every mem_rw=0 cycle must match the head of the scoreboard.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.mem_rw !== 1'b1) begin
            if (writes_seen == 0) first_wr_cyc = cyc_cnt;
            last_wr_cyc = cyc_cnt;
            writes_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(bus.mem_rw), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
               check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
            end
         end
         if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_cnt;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic fill_random(input int n);
      word_t w;
      for (int i = 0; i < n; i++) begin
         w.opc = 3'($urandom_range(0, 7));
         w.opr = 8'($urandom_range(0, 255));
         w.exp = {w.opc, w.opr};
         src_q.push_back(w);
      end
   endtask

   task automatic start_session(input logic [6:0] cnt);
      exp_addr    = '0;
      writes_seen = 0;
      done_cnt    = 0;
      exp_q.delete();
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.count = cnt;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.count = '0;
   endtask

   // Offers src_q words; the expectation is queued at the negedge before the accepting edge.
   task automatic stream(input int budget);
      int cyc = 0;
      sent_cnt = 0;
      while (src_q.size() > 0 && cyc < budget) begin
         bus.in_valid   = 1'b1;
         bus.in_opcode  = src_q[0].opc;
         bus.in_operand = src_q[0].opr;
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            if (sent_cnt == 0) first_acc_cyc = cyc_cnt;
            exp_q.push_back('{addr: exp_addr, data: src_q[0].exp});
            exp_addr++;
            void'(src_q.pop_front());
            sent_cnt++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("stream_left", 32'(src_q.size()), 32'd0);
      src_q.delete();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
         n++;
      end
      check("done_seen", 32'(bus.done), 32'd1);
   endtask

   task automatic finish_session(input int n);
      wait_done(300);
      check("ww_at_done", 32'(bus.words_written), 32'(n));
      check("addr_at_done", 32'(bus.mem_addr), 32'(6'(n)));
      check("busy_in_fin", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("busy_after", 32'(bus.busy), 32'd0);
      check("done_width", 32'(bus.done), 32'd0);
      check("ww_hold", 32'(bus.words_written), 32'(n));
      check("writes_total", 32'(writes_seen), 32'(n));
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
   endtask

   task automatic run_session(input sess_t s);
      fill_random(s.exp_writes);
      start_session(s.count);
      check("busy_on_start", 32'(bus.busy), 32'd1);
      check("ww_cleared", 32'(bus.words_written), 32'd0);
      bus.mem_wait = (s.stall > 0);
      fork
         stream(400);
         begin
            if (s.stall > 0) begin
               repeat (s.stall) @(negedge clk);
               check("stall_accepts", 32'(sent_cnt), 32'd4);
               check("stall_ready", 32'(bus.in_ready), 32'd0);
               check("stall_writes", 32'(writes_seen), 32'd0);
               bus.mem_wait = 1'b0;
            end
         end
         begin
            if (s.extra_start) begin
               repeat (2) begin
                  @(negedge clk);
                  bus.start = 1'b1;
                  bus.count = 7'd2;
                  @(negedge clk);
                  bus.start = 1'b0;
                  bus.count = '0;
               end
            end
         end
      join
      finish_session(s.exp_writes);
   endtask

   initial begin
      word_t w1[3];
      sess_t tbl[5];
      int    n;
      int    cyc;

      w1[0] = '{opc: 3'd2, opr: 8'h92, exp: 11'h292};
      w1[1] = '{opc: 3'd3, opr: 8'h1A, exp: 11'h31A};
      w1[2] = '{opc: 3'd5, opr: 8'hD2, exp: 11'h5D2};
      tbl[0] = '{count: 7'd8,   exp_writes: 8,  stall: 12, extra_start: 1'b0};
      tbl[1] = '{count: 7'd64,  exp_writes: 64, stall: 0,  extra_start: 1'b0};
      tbl[2] = '{count: 7'd100, exp_writes: 64, stall: 0,  extra_start: 1'b0};
      tbl[3] = '{count: 7'd4,   exp_writes: 4,  stall: 0,  extra_start: 1'b1};
      tbl[4] = '{count: 7'd1,   exp_writes: 1,  stall: 0,  extra_start: 1'b0};

      rst = 1'b1;
      bus.start = 1'b0;      bus.count = '0;        bus.abort = 1'b0;
      bus.in_valid = 1'b0;   bus.in_opcode = '0;    bus.in_operand = '0;
      bus.mem_wait = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_rw", 32'(bus.mem_rw), 32'd1);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ww", 32'(bus.words_written), 32'd0);
      rst = 1'b0;

      // Fixed three-word load, back-to-back
      for (int i = 0; i < 3; i++) src_q.push_back(w1[i]);
      start_session(7'd3);
      stream(50);
      wait_done(50);
`ifdef LOADER_CHECKSUM_EN
      check("checksum", 32'(bus.checksum), 32'h88);
`endif
      @(negedge clk);
      check("s1_writes", 32'(writes_seen), 32'd3);
      check("s1_latency", 32'(first_wr_cyc - first_acc_cyc), 32'd2);
      check("s1_back_to_back", 32'(last_wr_cyc - first_wr_cyc), 32'd2);
      check("s1_done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
      check("s1_ww", 32'(bus.words_written), 32'd3);
      check("s1_done_pulses", 32'(done_cnt), 32'd1);

      for (int i = 0; i < 5; i++) run_session(tbl[i]);

      // Abort after the second write with two words still buffered
      fill_random(4);
      start_session(7'd8);
      bus.mem_wait = 1'b1;
      stream(50);
      check("abort_pre_ww", 32'(bus.words_written), 32'd0);
      @(negedge clk);
      bus.mem_wait = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 2 && cyc < 20) begin
         @(negedge clk);
         if (bus.mem_rw === 1'b0) n++;
         cyc++;
      end
      check("abort_two_writes", 32'(n), 32'd2);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check("abort_mem_rw", 32'(bus.mem_rw), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      check("abort_ww", 32'(bus.words_written), 32'd2);
      repeat (4) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_writes", 32'(writes_seen), 32'd2);
      check("abort_ww_hold", 32'(bus.words_written), 32'd2);
      exp_q.delete();

      run_session('{count: 7'd3, exp_writes: 3, stall: 0, extra_start: 1'b0});

      // Zero-length session: one done pulse, no writes
      start_session(7'd0);
      check("zero_done", 32'(bus.done), 32'd1);
      check("zero_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      check("zero_done_drop", 32'(bus.done), 32'd0);
      repeat (3) @(negedge clk);
      check("zero_pulses", 32'(done_cnt), 32'd1);
      check("zero_writes", 32'(writes_seen), 32'd0);

      // Asynchronous reset in the middle of a session
      fill_random(3);
      start_session(7'd8);
      stream(50);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_mem_rw", 32'(bus.mem_rw), 32'd1);
      check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("arst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_ww", 32'(bus.words_written), 32'd0);
      check("arst_in_ready", 32'(bus.in_ready), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;

      run_session('{count: 7'd2, exp_writes: 2, stall: 0, extra_start: 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
